// File: rtl/cla_bist.sv
// Built-in self test for a 4-bit carry-lookahead adder: drives LFSR-generated operands,
// waits a programmable settle time, and checks {cout,s} against an internal 5-bit sum.
module cla_bist #(
    parameter int unsigned NVEC   = 16,
    parameter int unsigned SETTLE = 1,
    parameter logic [8:0]  SEED   = 9'h1A5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic       cin,
    input  logic [3:0] s,
    input  logic       cout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
    output logic [7:0] first_fail
);

    // An all-zero LFSR would lock up, so a zero seed is replaced by 9'h001.
    localparam logic [8:0] SeedEff  = (SEED == 9'd0) ? 9'h001 : SEED;
    localparam logic [7:0] LastIdx  = 8'(NVEC - 1);
    localparam logic [3:0] WaitLast = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
    localparam logic [7:0] NoFail   = 8'hFF;

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StWait,
        StCheck,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [8:0] lfsr_q, lfsr_d;
    logic [7:0] vec_idx_q, vec_idx_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic       cin_q, cin_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [7:0] first_fail_q, first_fail_d;
    logic       pass_q, pass_d;

    logic [4:0] golden;
    logic       mismatch;
    logic       start_ok;

    assign golden   = {1'b0, a_q} + {1'b0, b_q} + {4'b0000, cin_q};
    assign mismatch = ({cout, s} != golden);
    assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StDrive;
                end
            end
            StDrive: begin
                state_d = (SETTLE == 0) ? StCheck : StWait;
            end
            StWait: begin
                if (wait_cnt_q == WaitLast) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                state_d = (vec_idx_q == LastIdx) ? StDone : StDrive;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            StDrive, StWait, StCheck: busy = 1'b1;
            StDone:                   done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath next-state
    always_comb begin
        lfsr_d       = lfsr_q;
        vec_idx_d    = vec_idx_q;
        wait_cnt_d   = wait_cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        cin_d        = cin_q;
        err_cnt_d    = err_cnt_q;
        first_fail_d = first_fail_q;
        pass_d       = pass_q;

        if (start_ok) begin
            lfsr_d       = SeedEff;
            vec_idx_d    = 8'd0;
            err_cnt_d    = 8'd0;
            first_fail_d = NoFail;
            pass_d       = 1'b0;
        end

        unique case (state_q)
            StDrive: begin
                a_d        = lfsr_q[8:5];
                b_d        = lfsr_q[4:1];
                cin_d      = lfsr_q[0];
                wait_cnt_d = 4'd0;
            end
            StWait: begin
                wait_cnt_d = wait_cnt_q + 4'd1;
            end
            StCheck: begin
                if (mismatch) begin
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    if (first_fail_q == NoFail) begin
                        first_fail_d = vec_idx_q;
                    end
                end
                // x^9 + x^5 + 1, shifting left
                lfsr_d    = {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]};
                vec_idx_d = vec_idx_q + 8'd1;
                if (vec_idx_q == LastIdx) begin
                    pass_d = (err_cnt_d == 8'd0);
                end
            end
            default: begin
                wait_cnt_d = wait_cnt_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q       <= SeedEff;
            vec_idx_q    <= 8'd0;
            wait_cnt_q   <= 4'd0;
            a_q          <= 4'd0;
            b_q          <= 4'd0;
            cin_q        <= 1'b0;
            err_cnt_q    <= 8'd0;
            first_fail_q <= NoFail;
            pass_q       <= 1'b0;
        end else begin
            lfsr_q       <= lfsr_d;
            vec_idx_q    <= vec_idx_d;
            wait_cnt_q   <= wait_cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cin_q        <= cin_d;
            err_cnt_q    <= err_cnt_d;
            first_fail_q <= first_fail_d;
            pass_q       <= pass_d;
        end
    end

    assign a          = a_q;
    assign b          = b_q;
    assign cin        = cin_q;
    assign err_cnt    = err_cnt_q;
    assign first_fail = first_fail_q;
    assign pass       = pass_q;

endmodule

// File: tb/tb_cla_bist.sv
// Directed bench for cla_bist: several instances with different parameters and adder models
// (golden, inverted sum, carry-out stuck at zero).
module tb_cla_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Main instance: default parameters, adder behaviour selected by mode
    logic [1:0] mode;
    logic       start_m, cin_m, cout_m, busy_m, done_m, pass_m;
    logic [3:0] a_m, b_m, s_m;
    logic [7:0] err_m, ff_m;
    logic [4:0] sum_m;

    always_comb begin
        sum_m  = {1'b0, a_m} + {1'b0, b_m} + {4'b0000, cin_m};
        s_m    = sum_m[3:0];
        cout_m = sum_m[4];
        if (mode == 2'd1) s_m = ~sum_m[3:0];
        if (mode == 2'd2) cout_m = 1'b0;
    end

    cla_bist u_main (
        .clk(clk), .rst_n(rst_n), .start(start_m), .a(a_m), .b(b_m), .cin(cin_m),
        .s(s_m), .cout(cout_m), .busy(busy_m), .done(done_m), .pass(pass_m),
        .err_cnt(err_m), .first_fail(ff_m)
    );

    // Short run: NVEC=1, SETTLE=0, SEED=0, golden adder
    logic       start_s, cin_s, cout_s, busy_s, done_s, pass_s;
    logic [3:0] a_s, b_s, s_s;
    logic [7:0] err_s, ff_s;
    assign {cout_s, s_s} = {1'b0, a_s} + {1'b0, b_s} + {4'b0000, cin_s};

    cla_bist #(.NVEC(1), .SETTLE(0), .SEED(9'h000)) u_short (
        .clk(clk), .rst_n(rst_n), .start(start_s), .a(a_s), .b(b_s), .cin(cin_s),
        .s(s_s), .cout(cout_s), .busy(busy_s), .done(done_s), .pass(pass_s),
        .err_cnt(err_s), .first_fail(ff_s)
    );

    // Carry-out stuck at zero, seeds chosen to force specific first vectors
    logic       start_c1, cin_c1, busy_c1, done_c1, pass_c1;
    logic [3:0] a_c1, b_c1, s_c1;
    logic [7:0] err_c1, ff_c1;
    assign s_c1 = a_c1 + b_c1 + {3'b000, cin_c1};

    cla_bist #(.NVEC(1), .SETTLE(2), .SEED(9'h132)) u_c1 (
        .clk(clk), .rst_n(rst_n), .start(start_c1), .a(a_c1), .b(b_c1), .cin(cin_c1),
        .s(s_c1), .cout(1'b0), .busy(busy_c1), .done(done_c1), .pass(pass_c1),
        .err_cnt(err_c1), .first_fail(ff_c1)
    );

    logic       start_c2, cin_c2, busy_c2, done_c2, pass_c2;
    logic [3:0] a_c2, b_c2, s_c2;
    logic [7:0] err_c2, ff_c2;
    assign s_c2 = a_c2 + b_c2 + {3'b000, cin_c2};

    cla_bist #(.NVEC(1), .SETTLE(1), .SEED(9'h026)) u_c2 (
        .clk(clk), .rst_n(rst_n), .start(start_c2), .a(a_c2), .b(b_c2), .cin(cin_c2),
        .s(s_c2), .cout(1'b0), .busy(busy_c2), .done(done_c2), .pass(pass_c2),
        .err_cnt(err_c2), .first_fail(ff_c2)
    );

    logic [8:0] exp_vec [16];
    logic [8:0] got_vec [16];

    function automatic logic [8:0] lfsr_step(input logic [8:0] l);
        return {l[7:0], l[8] ^ l[4]};
    endfunction

    // Pulse start, run to done (bounded), record each driven vector (SETTLE=1 spacing).
    task automatic run_main(input int repulse_at, output int n, output int busy_cnt);
        @(negedge clk) start_m = 1'b1;
        @(negedge clk) start_m = 1'b0;
        n = 0;
        busy_cnt = busy_m ? 1 : 0;
        for (int i = 0; i < 16; i++) got_vec[i] = 9'h000;
        while (!done_m && n < 200) begin
            n++;
            start_m = (n == repulse_at);
            @(negedge clk);
            if (busy_m) busy_cnt++;
            if ((n % 3) == 1 && (n / 3) < 16) got_vec[n / 3] = {a_m, b_m, cin_m};
        end
        start_m = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_m = 1'b1; start_s = 1'b1; start_c1 = 1'b0; start_c2 = 1'b0;
        mode = 2'd0;
        repeat (3) @(negedge clk);
        start_m = 1'b0; start_s = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({a_m, b_m, cin_m, busy_m, done_m, pass_m, err_m, ff_m} !== 28'h00000FF) begin
            miscompares++;
            $display("FAIL reset_main: got %h required %h",
                     {a_m, b_m, cin_m, busy_m, done_m, pass_m, err_m, ff_m}, 28'h00000FF);
        end
        vectors++;
        if ({a_s, b_s, cin_s, busy_s, done_s, pass_s, err_s, ff_s} !== 28'h00000FF) begin
            miscompares++;
            $display("FAIL reset_short: got %h required %h",
                     {a_s, b_s, cin_s, busy_s, done_s, pass_s, err_s, ff_s}, 28'h00000FF);
        end
    endtask

    task automatic test_golden_run();
        int n, bc;
        mode = 2'd0;
        run_main(0, n, bc);
        vectors++;
        if (n !== 48) begin
            miscompares++; $display("FAIL golden_len: got %0d required 48", n);
        end
        vectors++;
        if (bc !== 48) begin
            miscompares++; $display("FAIL golden_busy: got %0d required 48", bc);
        end
        vectors++;
        if ({done_m, pass_m, err_m, ff_m} !== 18'h300FF) begin
            miscompares++;
            $display("FAIL golden_result: got %h required %h", {done_m, pass_m, err_m, ff_m},
                     18'h300FF);
        end
        vectors++;
        if (got_vec[0] !== 9'b1101_0010_1) begin
            miscompares++; $display("FAIL first_vec: got %b required 110100101", got_vec[0]);
        end
        vectors++;
        if (got_vec[1] !== 9'h14B) begin
            miscompares++; $display("FAIL second_vec: got %h required 14b", got_vec[1]);
        end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (got_vec[i] !== exp_vec[i]) begin
                miscompares++;
                $display("FAIL vec_%0d: got %h required %h", i, got_vec[i], exp_vec[i]);
            end
        end
    endtask

    task automatic test_done_hold();
        repeat (5) @(negedge clk);
        vectors++;
        if ({a_m, b_m, cin_m, done_m, pass_m, err_m, ff_m} !== {exp_vec[15], 18'h300FF}) begin
            miscompares++;
            $display("FAIL done_hold: got %h required %h",
                     {a_m, b_m, cin_m, done_m, pass_m, err_m, ff_m}, {exp_vec[15], 18'h300FF});
        end
    endtask

    task automatic test_inverted_s();
        int n, bc;
        mode = 2'd1;
        run_main(0, n, bc);
        vectors++;
        if (n !== 48) begin
            miscompares++; $display("FAIL inv_len: got %0d required 48", n);
        end
        vectors++;
        if ({done_m, pass_m, err_m, ff_m} !== {2'b10, 8'd16, 8'd0}) begin
            miscompares++;
            $display("FAIL inv_result: got %h required %h", {done_m, pass_m, err_m, ff_m},
                     {2'b10, 8'd16, 8'd0});
        end
    endtask

    task automatic test_restart_from_done();
        int n;
        mode = 2'd0;
        @(negedge clk) start_m = 1'b1;
        @(negedge clk) start_m = 1'b0;
        vectors++;
        if ({busy_m, done_m, pass_m, err_m, ff_m} !== 19'h400FF) begin
            miscompares++;
            $display("FAIL restart_clear: got %h required %h", {busy_m, done_m, pass_m, err_m, ff_m},
                     19'h400FF);
        end
        n = 0;
        while (!done_m && n < 200) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if ({n[7:0], pass_m, err_m} !== {8'd48, 1'b1, 8'd0}) begin
            miscompares++;
            $display("FAIL restart_run: got len %0d pass %b err %0d required 48 1 0", n, pass_m,
                     err_m);
        end
    endtask

    task automatic test_back_to_back_start();
        int n, bc;
        mode = 2'd0;
        run_main(10, n, bc);
        vectors++;
        if (n !== 48 || bc !== 48) begin
            miscompares++; $display("FAIL repulse_len: got %0d/%0d required 48/48", n, bc);
        end
        vectors++;
        if ({pass_m, err_m, ff_m} !== 17'h100FF) begin
            miscompares++;
            $display("FAIL repulse_result: got %h required %h", {pass_m, err_m, ff_m}, 17'h100FF);
        end
    endtask

    task automatic test_reset_midrun();
        int n, bc;
        mode = 2'd1;
        @(negedge clk) start_m = 1'b1;
        @(negedge clk) start_m = 1'b0;
        repeat (19) @(negedge clk);
        vectors++;
        if (err_m !== 8'd6) begin
            miscompares++; $display("FAIL midrun_err: got %0d required 6", err_m);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({a_m, b_m, cin_m, busy_m, done_m, pass_m, err_m, ff_m} !== 28'h00000FF) begin
            miscompares++;
            $display("FAIL midrun_reset: got %h required %h",
                     {a_m, b_m, cin_m, busy_m, done_m, pass_m, err_m, ff_m}, 28'h00000FF);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({a_m, b_m, cin_m, busy_m, done_m, pass_m, err_m, ff_m} !== 28'h00000FF) begin
            miscompares++;
            $display("FAIL midrun_idle: got %h required %h",
                     {a_m, b_m, cin_m, busy_m, done_m, pass_m, err_m, ff_m}, 28'h00000FF);
        end
        mode = 2'd0;
        run_main(0, n, bc);
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (got_vec[i] !== exp_vec[i]) begin
                miscompares++;
                $display("FAIL rerun_vec_%0d: got %h required %h", i, got_vec[i], exp_vec[i]);
            end
        end
        vectors++;
        if ({n[7:0], pass_m} !== {8'd48, 1'b1}) begin
            miscompares++; $display("FAIL rerun_result: got len %0d pass %b", n, pass_m);
        end
    endtask

    task automatic test_cout_stuck();
        int n;
        @(negedge clk) begin start_c1 = 1'b1; start_c2 = 1'b1; end
        @(negedge clk) begin start_c1 = 1'b0; start_c2 = 1'b0; end
        n = 0;
        while (!done_c1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (n !== 4) begin
            miscompares++; $display("FAIL stuck1_len: got %0d required 4", n);
        end
        vectors++;
        if ({a_c1, b_c1, cin_c1, pass_c1, err_c1, ff_c1} !== {9'b1001_1001_0, 1'b0, 8'd1, 8'd0})
        begin
            miscompares++;
            $display("FAIL stuck1_result: got %h required %h",
                     {a_c1, b_c1, cin_c1, pass_c1, err_c1, ff_c1},
                     {9'b1001_1001_0, 1'b0, 8'd1, 8'd0});
        end
        vectors++;
        if ({done_c2, a_c2, b_c2, cin_c2, pass_c2, err_c2, ff_c2} !==
            {1'b1, 9'b0001_0011_0, 1'b1, 8'd0, 8'hFF}) begin
            miscompares++;
            $display("FAIL stuck2_result: got %h required %h",
                     {done_c2, a_c2, b_c2, cin_c2, pass_c2, err_c2, ff_c2},
                     {1'b1, 9'b0001_0011_0, 1'b1, 8'd0, 8'hFF});
        end
    endtask

    task automatic test_short_seed0();
        int n;
        @(negedge clk) start_s = 1'b1;
        @(negedge clk) start_s = 1'b0;
        n = 0;
        while (!done_s && n < 50) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (n !== 2) begin
            miscompares++; $display("FAIL short_len: got %0d required 2", n);
        end
        vectors++;
        if ({a_s, b_s, cin_s, busy_s, pass_s, err_s, ff_s} !== {9'h001, 1'b0, 1'b1, 8'd0, 8'hFF})
        begin
            miscompares++;
            $display("FAIL short_result: got %h required %h",
                     {a_s, b_s, cin_s, busy_s, pass_s, err_s, ff_s},
                     {9'h001, 1'b0, 1'b1, 8'd0, 8'hFF});
        end
    endtask

    initial begin
        logic [8:0] l;
        l = 9'h1A5;
        for (int i = 0; i < 16; i++) begin
            exp_vec[i] = l;
            l = lfsr_step(l);
        end
        test_reset();
        test_golden_run();
        test_done_hold();
        test_inverted_s();
        test_restart_from_done();
        test_back_to_back_start();
        test_reset_midrun();
        test_cout_stuck();
        test_short_seed0();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
